// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch select/adjust core: state encoding,
// default moduli and the count-width sanity check used at elaboration.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_e;

    localparam int SEC_MOD_DEFAULT = 60;
    localparam int MIN_MOD_DEFAULT = 60;

    // True when a w-bit count can hold every value 0..max(sec_mod,min_mod)-1.
    function automatic bit width_ok(input int w, input int sec_mod, input int min_mod);
        int largest;
        largest = (sec_mod > min_mod) ? sec_mod : min_mod;
        if (w < 1 || w > 30) begin
            return 1'b0;
        end
        return ((1 << w) >= largest);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear. wrap flags the increment
// that takes the count from MOD-1 back to 0, so a neighbour can carry on it.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign wrap = inc & (q_q == LAST);
    assign q    = q_q;

    // Next count: clear beats increment; increment wraps at the modulus.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = wrap ? '0 : (q_q + W'(1));
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_adj_core.sv
// Stopwatch run/pause/adjust core. Owns the minutes and seconds counters,
// advances them on tick enables and reports a one-cycle rollover when the
// minutes field wraps while running.
// Optional build macro STOPWATCH_BLINK_EN adds blank_min/blank_sec outputs
// that flash the field being adjusted at half the adjust tick rate.
module stopwatch_adj_core
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD = SEC_MOD_DEFAULT,
    parameter int MIN_MOD = MIN_MOD_DEFAULT,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_p,
    input  logic             clear_p,
    output logic [CNT_W-1:0] minutes,
    output logic [CNT_W-1:0] seconds,
    output logic             running,
    output logic             adjusting,
    output logic             rollover
`ifdef STOPWATCH_BLINK_EN
    ,
    output logic             blank_min,
    output logic             blank_sec
`endif
);

    if (!width_ok(CNT_W, SEC_MOD, MIN_MOD)) begin : g_width_fail
        $error("stopwatch_adj_core: CNT_W too small for SEC_MOD/MIN_MOD");
    end

    state_e state_q;
    state_e state_d;
    logic   rollover_q;
    logic   rollover_d;

    logic   run_tick;
    logic   adj_tick;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_wrap;
    logic   min_wrap;

    // Ticks are qualified by the state held before any same-cycle transition.
    always_comb begin
        run_tick = (state_q == RUN) & tick_1hz;
        adj_tick = (state_q == ADJUST) & tick_2hz;
        sec_inc  = run_tick | (adj_tick & sel);
        min_inc  = (run_tick & sec_wrap) | (adj_tick & ~sel);
    end

    mod_counter #(
        .MOD (SEC_MOD),
        .W   (CNT_W)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (clear_p),
        .q     (seconds),
        .wrap  (sec_wrap)
    );

    mod_counter #(
        .MOD (MIN_MOD),
        .W   (CNT_W)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (clear_p),
        .q     (minutes),
        .wrap  (min_wrap)
    );

    // Next state: adj wins over pause_p; leaving ADJUST always parks in PAUSED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (adj) begin
                    state_d = ADJUST;
                end else if (pause_p) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (adj) begin
                    state_d = ADJUST;
                end else if (pause_p) begin
                    state_d = RUN;
                end
            end
            ADJUST: begin
                if (!adj) begin
                    state_d = PAUSED;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Rollover pulse lines up with the cycle the counts show 00:00; a clear wins.
    always_comb begin
        rollover_d = run_tick & sec_wrap & min_wrap & ~clear_p;
    end

    // State and rollover registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rollover_q <= rollover_d;
        end
    end

    assign running   = (state_q == RUN);
    assign adjusting = (state_q == ADJUST);
    assign rollover  = rollover_q;

`ifdef STOPWATCH_BLINK_EN
    logic phase_q;
    logic phase_d;

    // Blink phase restarts dark-free on ADJUST entry and flips on each adjust tick.
    always_comb begin
        phase_d = phase_q;
        if ((state_q != ADJUST) && (state_d == ADJUST)) begin
            phase_d = 1'b0;
        end else if (adj_tick) begin
            phase_d = ~phase_q;
        end
    end

    // Blink phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign blank_sec = adjusting & sel & phase_q;
    assign blank_min = adjusting & ~sel & phase_q;
`endif

endmodule

// File: tb/tb_stopwatch_adj_core.sv
// Directed self-checking bench for stopwatch_adj_core (default 60/60 moduli).
module tb_stopwatch_adj_core;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       adj;
    logic       sel;
    logic       pause_p;
    logic       clear_p;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       adjusting;
    logic       rollover;
`ifdef STOPWATCH_BLINK_EN
    logic       blank_min;
    logic       blank_sec;
`endif

    int total;
    int bad;

    stopwatch_adj_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .adj       (adj),
        .sel       (sel),
        .pause_p   (pause_p),
        .clear_p   (clear_p),
        .minutes   (minutes),
        .seconds   (seconds),
        .running   (running),
        .adjusting (adjusting),
        .rollover  (rollover)
`ifdef STOPWATCH_BLINK_EN
        ,
        .blank_min (blank_min),
        .blank_sec (blank_sec)
`endif
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put the watch in ADJUST, clear it, dial in m:s, then return to RUN.
    task automatic load_time(input int m, input int s);
        adj = 1'b1;
        step();
        clear_p = 1'b1;
        step();
        clear_p = 1'b0;
        sel = 1'b0;
        for (int i = 0; i < m; i++) begin
            tick_2hz = 1'b1;
            step();
            tick_2hz = 1'b0;
        end
        sel = 1'b1;
        for (int i = 0; i < s; i++) begin
            tick_2hz = 1'b1;
            step();
            tick_2hz = 1'b0;
        end
        adj = 1'b0;
        step();
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (minutes !== 6'd0 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL reset_counts got=%0d:%0d exp=0:0", minutes, seconds); end
        total++; if (running !== 1'b1 || adjusting !== 1'b0 || rollover !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got run=%b adj=%b roll=%b exp run=1 adj=0 roll=0", running, adjusting, rollover); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_run_count();
        bit seen_roll;
        seen_roll = 1'b0;
        for (int i = 0; i < 61; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            if (rollover === 1'b1) seen_roll = 1'b1;
            step();
            if (rollover === 1'b1) seen_roll = 1'b1;
        end
        total++; if (minutes !== 6'd1 || seconds !== 6'd1) begin bad++; $display("[TB] FAIL run61_counts got=%0d:%0d exp=1:1", minutes, seconds); end
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL run61_running got=%b exp=1", running); end
        total++; if (seen_roll !== 1'b0) begin bad++; $display("[TB] FAIL run61_rollover got=%b exp=0", seen_roll); end
    endtask

    task automatic test_rollover();
        load_time(59, 59);
        total++; if (minutes !== 6'd59 || seconds !== 6'd59 || running !== 1'b1) begin bad++; $display("[TB] FAIL preload got=%0d:%0d run=%b exp=59:59 run=1", minutes, seconds, running); end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        total++; if (minutes !== 6'd0 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL wrap_counts got=%0d:%0d exp=0:0", minutes, seconds); end
        total++; if (rollover !== 1'b1) begin bad++; $display("[TB] FAIL rollover_pulse got=%b exp=1", rollover); end
        step();
        total++; if (rollover !== 1'b0) begin bad++; $display("[TB] FAIL rollover_width got=%b exp=0", rollover); end
    endtask

    task automatic test_adjust();
        adj = 1'b1;
        sel = 1'b1;
        step();
        total++; if (adjusting !== 1'b1 || running !== 1'b0) begin bad++; $display("[TB] FAIL adj_entry got adj=%b run=%b exp adj=1 run=0", adjusting, running); end
`ifdef STOPWATCH_BLINK_EN
        total++; if (blank_sec !== 1'b0 || blank_min !== 1'b0) begin bad++; $display("[TB] FAIL blink_entry got sec=%b min=%b exp 0 0", blank_sec, blank_min); end
`endif
        for (int i = 0; i < 59; i++) begin
            tick_2hz = 1'b1;
            step();
            tick_2hz = 1'b0;
        end
        total++; if (minutes !== 6'd0 || seconds !== 6'd59) begin bad++; $display("[TB] FAIL adj_sec59 got=%0d:%0d exp=0:59", minutes, seconds); end
`ifdef STOPWATCH_BLINK_EN
        total++; if (blank_sec !== 1'b1 || blank_min !== 1'b0) begin bad++; $display("[TB] FAIL blink_sec got sec=%b min=%b exp 1 0", blank_sec, blank_min); end
`endif
        tick_2hz = 1'b1;
        step();
        tick_2hz = 1'b0;
        total++; if (minutes !== 6'd0 || seconds !== 6'd0 || rollover !== 1'b0) begin bad++; $display("[TB] FAIL adj_sec_wrap got=%0d:%0d roll=%b exp=0:0 roll=0", minutes, seconds, rollover); end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        total++; if (minutes !== 6'd0 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL adj_ignore_1hz got=%0d:%0d exp=0:0", minutes, seconds); end
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_2hz = 1'b1;
            step();
            tick_2hz = 1'b0;
        end
        total++; if (minutes !== 6'd3 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL adj_min3 got=%0d:%0d exp=3:0", minutes, seconds); end
`ifdef STOPWATCH_BLINK_EN
        total++; if (blank_min !== 1'b1 || blank_sec !== 1'b0) begin bad++; $display("[TB] FAIL blink_min got min=%b sec=%b exp 1 0", blank_min, blank_sec); end
`endif
        adj = 1'b0;
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        total++; if (running !== 1'b0 || adjusting !== 1'b0) begin bad++; $display("[TB] FAIL adj_exit got run=%b adj=%b exp 0 0", running, adjusting); end
    endtask

    task automatic test_paused();
        for (int i = 0; i < 10; i++) begin
            tick_1hz = 1'b1;
            tick_2hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            tick_2hz = 1'b0;
        end
        total++; if (minutes !== 6'd3 || seconds !== 6'd0 || running !== 1'b0) begin bad++; $display("[TB] FAIL paused_hold got=%0d:%0d run=%b exp=3:0 run=0", minutes, seconds, running); end
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL resume got=%b exp=1", running); end
        pause_p = 1'b1;
        tick_1hz = 1'b1;
        step();
        pause_p = 1'b0;
        tick_1hz = 1'b0;
        total++; if (seconds !== 6'd1 || running !== 1'b0) begin bad++; $display("[TB] FAIL pause_with_tick got sec=%0d run=%b exp sec=1 run=0", seconds, running); end
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
    endtask

    task automatic test_clear();
        load_time(12, 34);
        total++; if (minutes !== 6'd12 || seconds !== 6'd34 || running !== 1'b1) begin bad++; $display("[TB] FAIL clear_preload got=%0d:%0d run=%b exp=12:34 run=1", minutes, seconds, running); end
        clear_p = 1'b1;
        tick_1hz = 1'b1;
        step();
        clear_p = 1'b0;
        tick_1hz = 1'b0;
        total++; if (minutes !== 6'd0 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL clear_counts got=%0d:%0d exp=0:0", minutes, seconds); end
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL clear_state got run=%b exp=1", running); end
    endtask

    task automatic test_reset_mid_adjust();
        load_time(7, 30);
        adj = 1'b1;
        step();
        total++; if (minutes !== 6'd7 || seconds !== 6'd30 || adjusting !== 1'b1) begin bad++; $display("[TB] FAIL mid_adj_setup got=%0d:%0d adj=%b exp=7:30 adj=1", minutes, seconds, adjusting); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (minutes !== 6'd0 || seconds !== 6'd0) begin bad++; $display("[TB] FAIL async_reset_counts got=%0d:%0d exp=0:0", minutes, seconds); end
        total++; if (running !== 1'b1 || adjusting !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_state got run=%b adj=%b exp 1 0", running, adjusting); end
`ifdef STOPWATCH_BLINK_EN
        total++; if (blank_min !== 1'b0 || blank_sec !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_blank got min=%b sec=%b exp 0 0", blank_min, blank_sec); end
`endif
        adj = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Scenario sequence and summary.
    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        adj      = 1'b0;
        sel      = 1'b0;
        pause_p  = 1'b0;
        clear_p  = 1'b0;
        test_reset();
        test_run_count();
        test_rollover();
        test_adjust();
        test_paused();
        test_clear();
        test_reset_mid_adjust();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_adj_core.md
Name: stopwatch_adj_core

Overview:
- Parametrised successor to the stopwatch select/adjust logic.
- Owns the minutes and seconds registers directly, with configurable moduli and width.
- Driven by single-cycle tick enables rather than derived clocks; adds pause/run, clear and rollover signalling.
- Sits between the tick generator (1 Hz / 2 Hz enables) and the seven-segment display driver.

Parameters:
- SEC_MOD, 60, seconds modulus; seconds count 0..SEC_MOD-1.
- MIN_MOD, 60, minutes modulus; minutes count 0..MIN_MOD-1.
- CNT_W, 6, width of each count output; must satisfy 2**CNT_W >= max(SEC_MOD, MIN_MOD), otherwise elaboration fails.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  single-cycle run-rate enable, synchronous to clk.
- tick_2hz  in  1  single-cycle adjust-rate enable, synchronous to clk.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
- pause_p  in  1  debounced single-cycle pulse; toggles run/pause.
- clear_p  in  1  debounced single-cycle pulse; zeroes both counts.
- minutes  out  CNT_W  registered minutes count.
- seconds  out  CNT_W  registered seconds count.
- running  out  1  1 when state = RUN.
- adjusting  out  1  1 when state = ADJUST.
- rollover  out  1  one-cycle pulse when minutes wraps MIN_MOD-1 -> 0 in RUN.

Behaviour:
- Reset (rst_n low, async): minutes=0, seconds=0, state=RUN, rollover=0, all internal flops 0.
- States and transitions (one per clk):
  - RUN: pause_p -> PAUSED.
  - PAUSED: pause_p -> RUN.
  - adj=1 in RUN or PAUSED -> ADJUST. adj has priority over a simultaneous pause_p.
  - ADJUST: adj=0 -> PAUSED always; the user must resume explicitly. pause_p is ignored in ADJUST.
- Count updates are registered and take effect the cycle after the enabling input is sampled.
- RUN, on tick_1hz:
  - seconds+1.
  - If seconds==SEC_MOD-1: seconds->0 and minutes+1 in the same cycle.
  - If minutes==MIN_MOD-1 as well: minutes->0 and rollover=1 for exactly one cycle.
  - tick_2hz is ignored.
- PAUSED: counts hold; both ticks are ignored.
- ADJUST, on tick_2hz:
  - sel=1: seconds+1 modulo SEC_MOD, with no carry into minutes.
  - sel=0: minutes+1 modulo MIN_MOD; seconds unchanged.
  - rollover is never asserted. tick_1hz is ignored.
- A sel change is sampled on each tick, so there is no glitch between fields.
- clear_p zeroes both counts in any state and outranks any same-cycle tick. It does not change state.
- State transition and tick in the same cycle: the tick is evaluated against the pre-transition state (e.g. pause_p + tick_1hz in RUN -> count advances, then PAUSED).
- Arithmetic: unsigned compare-and-wrap. No overflow beyond modulus-1 is reachable.

Optional Feature:
- Macro: STOPWATCH_BLINK_EN.
- With the macro defined:
  - Adds outputs blank_min and blank_sec (1 bit each).
  - An internal phase flop toggles on every tick_2hz while in ADJUST and is cleared on ADJUST entry and on reset.
  - blank_sec = adjusting & sel & phase; blank_min = adjusting & ~sel & phase. Both are 0 outside ADJUST.
- Without the macro: the ports and phase flop are absent; behaviour is otherwise identical.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding enum (RUN=2'd0, PAUSED=2'd1, ADJUST=2'd2);
  - default SEC_MOD and MIN_MOD constants;
  - a width-check function.
- One sub-module, mod_counter:
  - parameters MOD, W;
  - inputs clk, rst_n, inc, clr;
  - outputs q[W-1:0] and wrap, where wrap = inc & (q==MOD-1) (combinational).
- Instantiated twice; the top level holds the FSM and carry/enable gating.

Test Plan:
- Reset, then 61 tick_1hz in RUN -> minutes=1, seconds=1, running=1, rollover never high.
- Preload 59:59 via ADJUST, drop adj, pause_p, one tick_1hz -> 00:00, rollover high exactly one cycle.
- adj=1, sel=1, seconds=59, one tick_2hz -> seconds=0, minutes unchanged; sel=0, three tick_2hz -> minutes+3.
- PAUSED with 10 tick_1hz and 10 tick_2hz -> counts unchanged; pause_p -> running=1.
- clear_p coincident with tick_1hz at 12:34 in RUN -> 00:00 next cycle, state still RUN.
- Assert rst_n low mid-adjust at 07:30 -> immediate 00:00, state RUN, adjusting=0. With STOPWATCH_BLINK_EN, blank_* = 0.
